// File: rtl/frame_scan_ctrl.sv
// -----------------------------------------------------------------------------
// frame_scan_ctrl
//
// Frame sequencer that sits in front of the pixel pipeline
// (rgb2i -> sobel -> threshold -> flood x2 -> CC). It accepts a valid/ready
// pixel stream, drives one pipeline enable per accepted pixel together with
// the pixel's x/y position, and drains the line buffers with FLUSH_CYCLES
// zero-pixel enables after the last pixel. It marks which enables carry a real
// output pixel (out_valid with out_x/out_y) and pulses frame_done once the
// flush has completed.
//
// Handshake: in_ready is high exactly while the controller is in RUN. A pixel
// is accepted on a rising clk edge where in_valid & in_ready; in_data must be
// stable with in_valid and is not required to be held once accepted.
//
// Optional feature macro: SCAN_FRAME_COUNT_EN
//   defined   -> frame_count counts completed frames (wraps, reset-only clear)
//   undefined -> frame_count is tied to zero
//
// Ports
//   clk          in   1        clock, all logic on posedge
//   reset_n      in   1        synchronous active-low reset
//   start        in   1        begin one frame (honoured only in IDLE)
//   abort        in   1        cancel current frame
//   in_valid     in   1        input pixel valid
//   in_data      in   PIXEL_W  input pixel {B,G,R}
//   in_ready     out  1        controller accepts a pixel this cycle
//   pipe_en      out  1        pipeline enable (one enable = one pixel shift)
//   pipe_x       out  LOC_W    column of pipe_data
//   pipe_y       out  LOC_W    row of pipe_data
//   pipe_data    out  PIXEL_W  pixel into pipeline
//   out_valid    out  1        pipeline output on this enable is a real pixel
//   out_x        out  LOC_W    column of that output pixel
//   out_y        out  LOC_W    row of that output pixel
//   busy         out  1        controller is not idle
//   frame_done   out  1        one-cycle pulse after the flush completes
//   frame_count  out  16       completed frames (see macro above)
//   dbg_state    out  2        current FSM state (0 IDLE,1 RUN,2 FLUSH,3 DONE)
// -----------------------------------------------------------------------------
module frame_scan_ctrl #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int LOC_W        = 11,
   parameter int PIXEL_W      = 24,
   parameter int FLUSH_CYCLES = 2576
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [PIXEL_W-1:0] in_data,
   output logic               in_ready,
   output logic               pipe_en,
   output logic [LOC_W-1:0]   pipe_x,
   output logic [LOC_W-1:0]   pipe_y,
   output logic [PIXEL_W-1:0] pipe_data,
   output logic               out_valid,
   output logic [LOC_W-1:0]   out_x,
   output logic [LOC_W-1:0]   out_y,
   output logic               busy,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [1:0]         dbg_state
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] FLUSH_N = CNT_W'(FLUSH_CYCLES);
   localparam logic [LOC_W-1:0] X_LAST  = LOC_W'(FRAME_WIDTH - 1);
   localparam logic [LOC_W-1:0] Y_LAST  = LOC_W'(FRAME_HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [LOC_W-1:0]   r_x;
   logic [LOC_W-1:0]   r_y;
   logic [CNT_W-1:0]   r_en_cnt;     // enables issued this frame, saturating
   logic [CNT_W-1:0]   r_flush_cnt;  // flush enables issued so far
   logic               r_pipe_en;
   logic [LOC_W-1:0]   r_pipe_x;
   logic [LOC_W-1:0]   r_pipe_y;
   logic [PIXEL_W-1:0] r_pipe_data;
   logic               r_out_valid;
   logic [LOC_W-1:0]   r_out_x;
   logic [LOC_W-1:0]   r_out_y;
   logic               r_frame_done;

   logic w_accept;
   logic w_en_sat;
   logic w_abort;
   logic w_frame_end;

   assign w_accept    = in_valid & (r_state == S_RUN);
   // Once FLUSH_CYCLES enables have gone in, every further enable pushes a
   // real pixel out of the far end of the pipeline.
   assign w_en_sat    = (r_en_cnt == FLUSH_N);
   assign w_abort     = abort & (r_state != S_IDLE);
   // The cycle after the last flush enable: move to DONE and raise frame_done.
   assign w_frame_end = (r_state == S_FLUSH) & (r_flush_cnt == FLUSH_N) & ~abort;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_en_cnt     <= '0;
         r_flush_cnt  <= '0;
         r_pipe_en    <= 1'b0;
         r_pipe_x     <= '0;
         r_pipe_y     <= '0;
         r_pipe_data  <= '0;
         r_out_valid  <= 1'b0;
         r_out_x      <= '0;
         r_out_y      <= '0;
         r_frame_done <= 1'b0;
      end else if (w_abort) begin
         // Abort wins over start and over a pixel accept in the same cycle.
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_en_cnt     <= '0;
         r_flush_cnt  <= '0;
         r_pipe_en    <= 1'b0;
         r_pipe_x     <= '0;
         r_pipe_y     <= '0;
         r_pipe_data  <= '0;
         r_out_valid  <= 1'b0;
         r_out_x      <= '0;
         r_out_y      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_pipe_en    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;

         // out_x/out_y name the pixel currently flagged by out_valid, so the
         // raster counter steps only after that pixel has been presented.
         if (r_out_valid) begin
            if (r_out_x == X_LAST) begin
               r_out_x <= '0;
               r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + LOC_W'(1);
            end else begin
               r_out_x <= r_out_x + LOC_W'(1);
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_RUN;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_out_x     <= '0;
                  r_out_y     <= '0;
                  r_en_cnt    <= '0;
                  r_flush_cnt <= '0;
               end
            end

            S_RUN: begin
               if (w_accept) begin
                  r_pipe_en   <= 1'b1;
                  r_pipe_data <= in_data;
                  r_pipe_x    <= r_x;
                  r_pipe_y    <= r_y;
                  r_out_valid <= w_en_sat;
                  if (!w_en_sat) begin
                     r_en_cnt <= r_en_cnt + CNT_W'(1);
                  end
                  if (r_x == X_LAST) begin
                     r_x <= '0;
                     r_y <= (r_y == Y_LAST) ? '0 : r_y + LOC_W'(1);
                     if (r_y == Y_LAST) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                     end
                  end else begin
                     r_x <= r_x + LOC_W'(1);
                  end
               end
            end

            S_FLUSH: begin
               if (r_flush_cnt != FLUSH_N) begin
                  r_pipe_en   <= 1'b1;
                  r_pipe_data <= '0;
                  r_pipe_x    <= '0;
                  r_pipe_y    <= '0;
                  r_out_valid <= w_en_sat;
                  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                  if (!w_en_sat) begin
                     r_en_cnt <= r_en_cnt + CNT_W'(1);
                  end
               end else begin
                  r_state      <= S_DONE;
                  r_frame_done <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SCAN_FRAME_COUNT_EN
   logic [15:0] r_frame_count;

   // Steps together with frame_done; only reset clears it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_frame_count <= '0;
      end else if (w_frame_end) begin
         r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_count = r_frame_count;
`else
   assign frame_count = 16'd0;
`endif

   assign in_ready   = (r_state == S_RUN);
   assign busy       = (r_state != S_IDLE);
   assign pipe_en    = r_pipe_en;
   assign pipe_x     = r_pipe_x;
   assign pipe_y     = r_pipe_y;
   assign pipe_data  = r_pipe_data;
   assign out_valid  = r_out_valid;
   assign out_x      = r_out_x;
   assign out_y      = r_out_y;
   assign frame_done = r_frame_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_scan_ctrl
//
// Directed bench for frame_scan_ctrl with a 4x3 frame and a 5-enable flush.
// Every enable / frame_done the DUT presents is popped from an expected queue
// filled by the stimulus, so stimulus and checking run independently.
// -----------------------------------------------------------------------------
module tb_frame_scan_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int F  = 5;
   localparam int LW = 11;
   localparam int PW = 24;
   localparam int NPIX = W * H;
   localparam int NEN  = NPIX + F;
   // {frame_done, pipe_en, out_valid, pipe_x, pipe_y, pipe_data, out_x, out_y}
   localparam int EW = 3 + 2 * LW + PW + 2 * LW;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic          in_valid;
   logic [PW-1:0] in_data;
   logic          in_ready;
   logic          pipe_en;
   logic [LW-1:0] pipe_x;
   logic [LW-1:0] pipe_y;
   logic [PW-1:0] pipe_data;
   logic          out_valid;
   logic [LW-1:0] out_x;
   logic [LW-1:0] out_y;
   logic          busy;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   frame_scan_ctrl #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .LOC_W       (LW),
      .PIXEL_W     (PW),
      .FLUSH_CYCLES(F)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .pipe_en    (pipe_en),
      .pipe_x     (pipe_x),
      .pipe_y     (pipe_y),
      .pipe_data  (pipe_data),
      .out_valid  (out_valid),
      .out_x      (out_x),
      .out_y      (out_y),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_count(frame_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [EW-1:0] exp_q[$];

   int first_en;
   int done_cyc;
   bit done_seen;
   int en_seen;
   int ov_seen;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] pix(input int p);
      return {8'(p), 8'hA5, 8'(p * 7 + 1)};
   endfunction

   function automatic logic [EW-1:0] mk(input logic fd, input logic en, input logic ov,
                                        input int x, input int y, input logic [PW-1:0] d,
                                        input int ox, input int oy);
      return {fd, en, ov, LW'(x), LW'(y), d, LW'(ox), LW'(oy)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Enable k of a frame: pixels 0..11 then zero flush enables; the pipeline
   // output is real from enable F onward, in raster order from (0,0).
   task automatic push_frame(input int n_en);
      for (int k = 0; k < n_en; k++) begin
         if (k < NPIX)
            exp_q.push_back(mk(1'b0, 1'b1, (k >= F), k % W, k / W, pix(k),
                               (k >= F) ? (k - F) % W : 0, (k >= F) ? (k - F) / W : 0));
         else
            exp_q.push_back(mk(1'b0, 1'b1, (k >= F), 0, 0, '0,
                               (k >= F) ? (k - F) % W : 0, (k >= F) ? (k - F) / W : 0));
      end
   endtask

   task automatic push_done();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 0, 0, '0, 0, 0));
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      if (pipe_en === 1'b1 || frame_done === 1'b1) begin
         act = {frame_done, pipe_en, out_valid, pipe_x, pipe_y, pipe_data,
                out_valid ? out_x : {LW{1'b0}}, out_valid ? out_y : {LW{1'b0}}};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got %0h expected none (t=%0t)", act, $time);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_err++;
               $display("FAIL scoreboard: got %0h expected %0h (t=%0t)", act, exp, $time);
            end
         end
         if (pipe_en === 1'b1) begin
            en_seen++;
            if (first_en < 0) first_en = cyc;
            if (out_valid === 1'b1) ov_seen++;
         end
         if (frame_done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_frame_stats();
      first_en  = -1;
      done_cyc  = -1;
      done_seen = 1'b0;
      en_seen   = 0;
      ov_seen   = 0;
   endtask

   task automatic wait_done(input string name);
      int budget;
      budget = 60;
      while (!done_seen && budget > 0) begin
         tick();
         budget--;
      end
      check({name, "_done_seen"}, 32'(done_seen), 32'd1);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_pipe_en"},    32'(pipe_en),    32'd0);
      check({name, "_in_ready"},   32'(in_ready),   32'd0);
      check({name, "_busy"},       32'(busy),       32'd0);
      check({name, "_out_valid"},  32'(out_valid),  32'd0);
      check({name, "_frame_done"}, 32'(frame_done), 32'd0);
      check({name, "_pipe_xy"},    32'({pipe_x, pipe_y}), 32'd0);
      check({name, "_pipe_data"},  32'(pipe_data),  32'd0);
      check({name, "_out_xy"},     32'({out_x, out_y}), 32'd0);
      check({name, "_frame_count"}, 32'(frame_count), 32'd0);
   endtask

   // Runs one frame from IDLE. gaps inserts an idle cycle after each pixel;
   // start_noise pulses start once in RUN and once in FLUSH.
   task automatic run_frame(input string name, input bit gaps, input bit start_noise);
      clear_frame_stats();
      push_frame(NEN);
      push_done();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < NPIX; p++) begin
         in_valid = 1'b1;
         in_data  = pix(p);
         if (start_noise && p == 3) start = 1'b1;
         if (p == 0) check({name, "_in_ready"}, 32'(in_ready), 32'd1);
         tick();
         start = 1'b0;
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = PW'($urandom_range(0, 24'hFFFFFF));
            tick();
         end
      end
      in_valid = 1'b0;
      if (start_noise) begin
         tick();
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      wait_done(name);
      if (!gaps) check({name, "_done_latency"}, 32'(done_cyc - first_en), 32'd17);
      tick();
      check({name, "_idle_after"}, 32'({busy, in_ready}), 32'd0);
      repeat (3) tick();
      check({name, "_en_total"}, 32'(en_seen), 32'(NEN));
      check({name, "_ov_total"}, 32'(ov_seen), 32'(NPIX));
      check({name, "_q_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      clear_frame_stats();
      repeat (3) tick();
      check_zero_outputs("reset");
      check("reset_state", 32'(dbg_state), 32'd0);
      reset_n = 1'b1;
      tick();

      // Back-to-back frame
      run_frame("b2b", 1'b0, 1'b0);

      // in_valid toggling 1,0,1,0
      run_frame("gaps", 1'b1, 1'b0);

      // Abort while pixel (2,1) is offered
      clear_frame_stats();
      push_frame(6);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 6; p++) begin
         in_valid = 1'b1;
         in_data  = pix(p);
         tick();
      end
      in_data = pix(6);
      abort   = 1'b1;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_pipe_en",  32'(pipe_en),  32'd0);
      repeat (25) tick();
      check("abort_no_done",   32'(done_seen),     32'd0);
      check("abort_q_drained", 32'(exp_q.size()), 32'd0);
      run_frame("after_abort", 1'b0, 1'b0);

      // start pulses in RUN and FLUSH are ignored
      run_frame("start_noise", 1'b0, 1'b1);

      // Reset while flushing
      clear_frame_stats();
      push_frame(NPIX + 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < NPIX; p++) begin
         in_valid = 1'b1;
         in_data  = pix(p);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("flush_state", 32'(dbg_state), 32'd2);
      tick();
      reset_n = 1'b0;
      tick();
      check_zero_outputs("flush_reset");
      reset_n = 1'b1;
      repeat (3) tick();
      check("flush_reset_q_drained", 32'(exp_q.size()), 32'd0);
      check("flush_reset_no_done",   32'(done_seen),     32'd0);

      // Three frames for the frame counter
      for (int f = 0; f < 3; f++) run_frame("count", 1'b0, 1'b0);
`ifdef SCAN_FRAME_COUNT_EN
      check("frame_count", 32'(frame_count), 32'd3);
`else
      check("frame_count", 32'(frame_count), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
